// File: rtl/ppu_vram_arbiter.sv
// ----------------------------------------------------------------------------
// ppu_vram_arbiter
//
// Shares the single-port 8 KiB VRAM between the background/window fetcher,
// the sprite fetcher and the CPU bus. The owner is re-evaluated on every
// T-cycle strobe from the PPU mode and the BG fetcher's memory-busy claim.
// Each access is issued combinationally by the current owner. The read data
// returned one clock later is steered by a registered tag to the requester
// that issued it. While the LCD is on and the PPU is drawing (mode 3), CPU
// reads return 0xFF, CPU writes are dropped, and a saturating counter records
// every refused CPU access.
//
// Ports
//   clk_in, rst_n_in         system clock, asynchronous active-low reset
//   tclk_in                  T-cycle strobe (one clk_in wide), owner update
//   lcd_on_in, ppu_mode_in   LCDC.7 and current PPU mode
//   bg_*                     BG fetcher address/request/busy, data/valid out
//   spr_*                    sprite fetcher address/request, data/valid out
//   cpu_*                    CPU address, rd/wr pulses, write data, read data
//                            and a one-clock read-done pulse
//   vram_*                   VRAM address/write-enable/write-data out and
//                            read data in (valid one clock after the address)
//   owner_out                current owner: 0 CPU, 1 BG, 2 SPR
//   cpu_blocked_count_out    saturating count of refused CPU accesses
// ----------------------------------------------------------------------------
module ppu_vram_arbiter #(
  parameter logic [15:0] VRAM_BASE   = 16'h8000,
  parameter int unsigned VRAM_DEPTH  = 32'd8192,
  parameter int unsigned BLOCK_CNT_W = 32'd8,
  localparam int unsigned AW         = $clog2(VRAM_DEPTH)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   tclk_in,
  input  logic                   lcd_on_in,
  input  logic [1:0]             ppu_mode_in,
  input  logic [15:0]            bg_addr_in,
  input  logic                   bg_addr_valid_in,
  input  logic                   bg_mem_busy_in,
  output logic [7:0]             bg_data_out,
  output logic                   bg_data_valid_out,
  input  logic [15:0]            spr_addr_in,
  input  logic                   spr_addr_valid_in,
  output logic [7:0]             spr_data_out,
  output logic                   spr_data_valid_out,
  input  logic [15:0]            cpu_addr_in,
  input  logic                   cpu_rd_in,
  input  logic                   cpu_wr_in,
  input  logic [7:0]             cpu_wdata_in,
  output logic [7:0]             cpu_rdata_out,
  output logic                   cpu_rdata_valid_out,
  output logic [AW-1:0]          vram_addr_out,
  output logic                   vram_we_out,
  output logic [7:0]             vram_wdata_out,
  input  logic [7:0]             vram_rdata_in,
  output logic [1:0]             owner_out,
  output logic [BLOCK_CNT_W-1:0] cpu_blocked_count_out
);

  typedef enum logic [1:0] {
    OWN_CPU = 2'd0,
    OWN_BG  = 2'd1,
    OWN_SPR = 2'd2
  } owner_e;

  // The tag names the requester whose read is in flight. TAG_NONE means that
  // nothing returns on the next clock.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_BG   = 2'd2,
    TAG_SPR  = 2'd3
  } tag_e;

  // The range bounds are held on 17 bits so that BASE + DEPTH cannot wrap.
  localparam logic [16:0] BASE_EXT  = {1'b0, VRAM_BASE};
  localparam logic [16:0] LIMIT_EXT = BASE_EXT + 17'(VRAM_DEPTH);
  localparam logic [BLOCK_CNT_W-1:0] CNT_MAX = {BLOCK_CNT_W{1'b1}};

  function automatic logic in_range(input logic [15:0] addr);
    return ({1'b0, addr} >= BASE_EXT) && ({1'b0, addr} < LIMIT_EXT);
  endfunction

  function automatic logic [AW-1:0] vram_offset(input logic [15:0] addr);
    return AW'(addr - VRAM_BASE);
  endfunction

  owner_e                 owner_q, owner_d;
  tag_e                   tag_q, tag_d;
  logic [7:0]             bg_data_q, bg_data_d;
  logic                   bg_valid_q, bg_valid_d;
  logic [15:0]            bg_req_addr_q, bg_req_addr_d;
  logic [7:0]             spr_data_q, spr_data_d;
  logic                   spr_valid_q, spr_valid_d;
  logic [15:0]            spr_req_addr_q, spr_req_addr_d;
  logic [7:0]             cpu_rdata_q, cpu_rdata_d;
  logic                   cpu_valid_q, cpu_valid_d;
  logic [BLOCK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  logic [AW-1:0] vram_addr_s;
  logic          vram_we_s;
  logic [7:0]    vram_wdata_s;
  logic          cpu_lock_s;
  logic          cpu_in_range_s;
  logic          bg_in_range_s;
  logic          spr_in_range_s;
  logic          cpu_access_s;
  logic          cpu_denied_s;
  logic          cpu_blk_rd_s;

  assign cpu_lock_s     = lcd_on_in && (ppu_mode_in == 2'd3);
  assign cpu_in_range_s = in_range(cpu_addr_in);
  assign bg_in_range_s  = in_range(bg_addr_in);
  assign spr_in_range_s = in_range(spr_addr_in);
  assign cpu_access_s   = (cpu_rd_in || cpu_wr_in) && cpu_in_range_s;
  // An in-range CPU access is refused during the mode-3 lockout. It is also
  // refused while a fetcher still owns VRAM, which can happen until the next
  // tclk after the lockout ends. Both cases answer the CPU the same way.
  assign cpu_denied_s   = cpu_lock_s || (owner_q != OWN_CPU);
  // When a read and a write arrive together, the write wins and no read data
  // returns, even when the write itself is refused.
  assign cpu_blk_rd_s   = cpu_access_s && cpu_denied_s && cpu_rd_in && !cpu_wr_in;

  // Ownership next state, which changes only on a T-cycle strobe.
  always_comb begin
    owner_d = owner_q;
    if (tclk_in) begin
      if (!lcd_on_in || (ppu_mode_in != 2'd3)) begin
        owner_d = OWN_CPU;
      end else if (bg_mem_busy_in) begin
        owner_d = OWN_BG;
      end else begin
        owner_d = OWN_SPR;
      end
    end else begin
      owner_d = owner_q;
    end
  end

  // Issue the current owner's access to VRAM and tag any read for the return.
  always_comb begin
    vram_addr_s  = '0;
    vram_we_s    = 1'b0;
    vram_wdata_s = 8'h00;
    tag_d        = TAG_NONE;
    case (owner_q)
      OWN_BG: begin
        if (bg_addr_valid_in && bg_in_range_s) begin
          vram_addr_s = vram_offset(bg_addr_in);
          tag_d       = TAG_BG;
        end else begin
          tag_d = TAG_NONE;
        end
      end
      OWN_SPR: begin
        if (spr_addr_valid_in && spr_in_range_s) begin
          vram_addr_s = vram_offset(spr_addr_in);
          tag_d       = TAG_SPR;
        end else begin
          tag_d = TAG_NONE;
        end
      end
      OWN_CPU: begin
        if (cpu_lock_s) begin
          tag_d = TAG_NONE;
        end else if (cpu_wr_in && cpu_in_range_s) begin
          vram_addr_s  = vram_offset(cpu_addr_in);
          vram_we_s    = 1'b1;
          vram_wdata_s = cpu_wdata_in;
        end else if (cpu_rd_in && cpu_in_range_s) begin
          vram_addr_s = vram_offset(cpu_addr_in);
          tag_d       = TAG_CPU;
        end else begin
          tag_d = TAG_NONE;
        end
      end
      default: begin
        tag_d = TAG_NONE;
      end
    endcase
  end

  // Fetcher return path. The valid flag is held only while the fetcher keeps
  // presenting the address that the data belongs to.
  always_comb begin
    bg_data_d      = bg_data_q;
    bg_valid_d     = bg_valid_q;
    bg_req_addr_d  = bg_req_addr_q;
    spr_data_d     = spr_data_q;
    spr_valid_d    = spr_valid_q;
    spr_req_addr_d = spr_req_addr_q;

    if (tag_d == TAG_BG) begin
      bg_req_addr_d = bg_addr_in;
    end else begin
      bg_req_addr_d = bg_req_addr_q;
    end
    if (tag_d == TAG_SPR) begin
      spr_req_addr_d = spr_addr_in;
    end else begin
      spr_req_addr_d = spr_req_addr_q;
    end

    if (tag_q == TAG_BG) begin
      bg_data_d  = vram_rdata_in;
      bg_valid_d = bg_addr_valid_in && (bg_addr_in == bg_req_addr_q);
    end else if (!bg_addr_valid_in || (bg_addr_in != bg_req_addr_q)) begin
      bg_valid_d = 1'b0;
    end else begin
      bg_valid_d = bg_valid_q;
    end

    if (tag_q == TAG_SPR) begin
      spr_data_d  = vram_rdata_in;
      spr_valid_d = spr_addr_valid_in && (spr_addr_in == spr_req_addr_q);
    end else if (!spr_addr_valid_in || (spr_addr_in != spr_req_addr_q)) begin
      spr_valid_d = 1'b0;
    end else begin
      spr_valid_d = spr_valid_q;
    end
  end

  // CPU return path and the saturating counter of refused accesses.
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    cpu_valid_d = 1'b0;
    blk_cnt_d   = blk_cnt_q;

    // A VRAM return takes priority over a refused-read answer in the same clock.
    if (tag_q == TAG_CPU) begin
      cpu_rdata_d = vram_rdata_in;
      cpu_valid_d = 1'b1;
    end else if (cpu_blk_rd_s) begin
      cpu_rdata_d = 8'hFF;
      cpu_valid_d = 1'b1;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
      cpu_valid_d = 1'b0;
    end

    if (cpu_access_s && cpu_denied_s && (blk_cnt_q != CNT_MAX)) begin
      blk_cnt_d = blk_cnt_q + BLOCK_CNT_W'(1);
    end else begin
      blk_cnt_d = blk_cnt_q;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      owner_q        <= OWN_CPU;
      tag_q          <= TAG_NONE;
      bg_data_q      <= 8'h00;
      bg_valid_q     <= 1'b0;
      bg_req_addr_q  <= 16'h0000;
      spr_data_q     <= 8'h00;
      spr_valid_q    <= 1'b0;
      spr_req_addr_q <= 16'h0000;
      cpu_rdata_q    <= 8'h00;
      cpu_valid_q    <= 1'b0;
      blk_cnt_q      <= '0;
    end else begin
      owner_q        <= owner_d;
      tag_q          <= tag_d;
      bg_data_q      <= bg_data_d;
      bg_valid_q     <= bg_valid_d;
      bg_req_addr_q  <= bg_req_addr_d;
      spr_data_q     <= spr_data_d;
      spr_valid_q    <= spr_valid_d;
      spr_req_addr_q <= spr_req_addr_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_valid_q    <= cpu_valid_d;
      blk_cnt_q      <= blk_cnt_d;
    end
  end

  assign bg_data_out           = bg_data_q;
  assign bg_data_valid_out     = bg_valid_q;
  assign spr_data_out          = spr_data_q;
  assign spr_data_valid_out    = spr_valid_q;
  assign cpu_rdata_out         = cpu_rdata_q;
  assign cpu_rdata_valid_out   = cpu_valid_q;
  assign vram_addr_out         = vram_addr_s;
  assign vram_we_out           = vram_we_s;
  assign vram_wdata_out        = vram_wdata_s;
  assign owner_out             = owner_q;
  assign cpu_blocked_count_out = blk_cnt_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// ----------------------------------------------------------------------------
// Directed testbench for ppu_vram_arbiter. A small VRAM model answers reads
// one clock after the address. It returns the last written byte for the
// written address, and a fixed address pattern for every other address.
// ----------------------------------------------------------------------------
module tb_ppu_vram_arbiter;

  logic        clk_in;
  logic        rst_n_in;
  logic        tclk_in;
  logic        lcd_on_in;
  logic [1:0]  ppu_mode_in;
  logic [15:0] bg_addr_in;
  logic        bg_addr_valid_in;
  logic        bg_mem_busy_in;
  logic [7:0]  bg_data_out;
  logic        bg_data_valid_out;
  logic [15:0] spr_addr_in;
  logic        spr_addr_valid_in;
  logic [7:0]  spr_data_out;
  logic        spr_data_valid_out;
  logic [15:0] cpu_addr_in;
  logic        cpu_rd_in;
  logic        cpu_wr_in;
  logic [7:0]  cpu_wdata_in;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_rdata_valid_out;
  logic [12:0] vram_addr_out;
  logic        vram_we_out;
  logic [7:0]  vram_wdata_out;
  logic [7:0]  vram_rdata_in;
  logic [1:0]  owner_out;
  logic [7:0]  cpu_blocked_count_out;

  int n_cmp  = 0;
  int n_fail = 0;

  ppu_vram_arbiter dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .tclk_in              (tclk_in),
    .lcd_on_in            (lcd_on_in),
    .ppu_mode_in          (ppu_mode_in),
    .bg_addr_in           (bg_addr_in),
    .bg_addr_valid_in     (bg_addr_valid_in),
    .bg_mem_busy_in       (bg_mem_busy_in),
    .bg_data_out          (bg_data_out),
    .bg_data_valid_out    (bg_data_valid_out),
    .spr_addr_in          (spr_addr_in),
    .spr_addr_valid_in    (spr_addr_valid_in),
    .spr_data_out         (spr_data_out),
    .spr_data_valid_out   (spr_data_valid_out),
    .cpu_addr_in          (cpu_addr_in),
    .cpu_rd_in            (cpu_rd_in),
    .cpu_wr_in            (cpu_wr_in),
    .cpu_wdata_in         (cpu_wdata_in),
    .cpu_rdata_out        (cpu_rdata_out),
    .cpu_rdata_valid_out  (cpu_rdata_valid_out),
    .vram_addr_out        (vram_addr_out),
    .vram_we_out          (vram_we_out),
    .vram_wdata_out       (vram_wdata_out),
    .vram_rdata_in        (vram_rdata_in),
    .owner_out            (owner_out),
    .cpu_blocked_count_out(cpu_blocked_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // VRAM model: one written location plus a fixed pattern elsewhere.
  logic        wr_seen_m = 1'b0;
  logic [12:0] wr_addr_m = 13'h0000;
  logic [7:0]  wr_data_m = 8'h00;

  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  always @(posedge clk_in) begin
    if (vram_we_out) begin
      wr_seen_m <= 1'b1;
      wr_addr_m <= vram_addr_out;
      wr_data_m <= vram_wdata_out;
    end
    if (wr_seen_m && (vram_addr_out == wr_addr_m)) vram_rdata_in <= wr_data_m;
    else vram_rdata_in <= pat(vram_addr_out);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_tclk();
    tclk_in = 1'b1;
    tick();
    tclk_in = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; tclk_in = 1'b0; lcd_on_in = 1'b1; ppu_mode_in = 2'd0;
    bg_addr_in = 16'h0000; bg_addr_valid_in = 1'b0; bg_mem_busy_in = 1'b0;
    spr_addr_in = 16'h0000; spr_addr_valid_in = 1'b0;
    cpu_addr_in = 16'h0000; cpu_rd_in = 1'b0; cpu_wr_in = 1'b0; cpu_wdata_in = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_owner", 32'(owner_out), 32'd0);
    check("rst_bg_data", 32'(bg_data_out), 32'h00);
    check("rst_bg_valid", 32'(bg_data_valid_out), 32'd0);
    check("rst_spr_valid", 32'(spr_data_valid_out), 32'd0);
    check("rst_cpu_valid", 32'(cpu_rdata_valid_out), 32'd0);
    check("rst_vram_addr", 32'(vram_addr_out), 32'h0000);
    check("rst_vram_we", 32'(vram_we_out), 32'd0);
    check("rst_count", 32'(cpu_blocked_count_out), 32'd0);
    rst_n_in = 1'b1;
    tick();

    // CPU write in mode 0
    cpu_addr_in = 16'h8010; cpu_wr_in = 1'b1; cpu_wdata_in = 8'h5A;
    #1;
    check("wr_we", 32'(vram_we_out), 32'd1);
    check("wr_addr", 32'(vram_addr_out), 32'h0010);
    check("wr_wdata", 32'(vram_wdata_out), 32'h5A);
    tick();
    cpu_wr_in = 1'b0; cpu_wdata_in = 8'h00;
    #1;
    check("wr_we_one_clk", 32'(vram_we_out), 32'd0);

    // CPU read back in mode 0
    cpu_rd_in = 1'b1;
    #1;
    check("rd_addr", 32'(vram_addr_out), 32'h0010);
    tick();
    cpu_rd_in = 1'b0;
    check("rd_valid_early", 32'(cpu_rdata_valid_out), 32'd0);
    tick();
    check("rd_valid", 32'(cpu_rdata_valid_out), 32'd1);
    check("rd_data", 32'(cpu_rdata_out), 32'h5A);
    tick();
    check("rd_valid_pulse", 32'(cpu_rdata_valid_out), 32'd0);
    check("rd_count", 32'(cpu_blocked_count_out), 32'd0);

    // CPU lockout in mode 3 with the LCD on
    ppu_mode_in = 2'd3;
    cpu_addr_in = 16'h9800; cpu_rd_in = 1'b1;
    #1;
    check("blk_rd_no_addr", 32'(vram_addr_out), 32'h0000);
    tick();
    cpu_rd_in = 1'b0;
    check("blk_rd_valid", 32'(cpu_rdata_valid_out), 32'd1);
    check("blk_rd_data", 32'(cpu_rdata_out), 32'hFF);
    check("blk_rd_count", 32'(cpu_blocked_count_out), 32'd1);
    cpu_wr_in = 1'b1; cpu_wdata_in = 8'h77;
    #1;
    check("blk_wr_we", 32'(vram_we_out), 32'd0);
    tick();
    cpu_wr_in = 1'b0;
    check("blk_wr_count", 32'(cpu_blocked_count_out), 32'd2);
    check("blk_wr_no_valid", 32'(cpu_rdata_valid_out), 32'd0);
    for (int i = 0; i < 300; i++) begin
      cpu_rd_in = 1'b1;
      tick();
      if (i == 251) check("blk_count_254", 32'(cpu_blocked_count_out), 32'd254);
    end
    cpu_rd_in = 1'b0;
    tick();
    check("blk_count_sat", 32'(cpu_blocked_count_out), 32'd255);

    // Handoff to BG
    bg_mem_busy_in = 1'b1;
    check("own_hold_cpu", 32'(owner_out), 32'd0);
    pulse_tclk();
    check("own_bg", 32'(owner_out), 32'd1);
    bg_addr_in = 16'h9C05; bg_addr_valid_in = 1'b1;
    #1;
    check("bg_addr", 32'(vram_addr_out), 32'h1C05);
    tick();
    check("bg_valid_early", 32'(bg_data_valid_out), 32'd0);
    tick();
    check("bg_valid", 32'(bg_data_valid_out), 32'd1);
    check("bg_data", 32'(bg_data_out), 32'h19);
    repeat (3) tick();
    check("bg_valid_hold", 32'(bg_data_valid_out), 32'd1);
    check("bg_spr_valid", 32'(spr_data_valid_out), 32'd0);
    bg_addr_valid_in = 1'b0;
    tick();
    check("bg_valid_drop", 32'(bg_data_valid_out), 32'd0);

    // Handoff to SPR
    bg_mem_busy_in = 1'b0;
    pulse_tclk();
    check("own_spr", 32'(owner_out), 32'd2);
    spr_addr_in = 16'h8020; spr_addr_valid_in = 1'b1;
    #1;
    check("spr_addr", 32'(vram_addr_out), 32'h0020);
    repeat (2) tick();
    check("spr_valid", 32'(spr_data_valid_out), 32'd1);
    check("spr_data", 32'(spr_data_out), 32'h20);
    spr_addr_valid_in = 1'b0;
    tick();
    check("spr_valid_drop", 32'(spr_data_valid_out), 32'd0);

    // A BG read issued as the owner switches to SPR is still delivered to BG
    bg_mem_busy_in = 1'b1;
    pulse_tclk();
    check("own_bg2", 32'(owner_out), 32'd1);
    tclk_in = 1'b1; bg_mem_busy_in = 1'b0;
    bg_addr_in = 16'h9C06; bg_addr_valid_in = 1'b1;
    #1;
    check("sw_bg_addr", 32'(vram_addr_out), 32'h1C06);
    tick();
    tclk_in = 1'b0;
    check("sw_owner", 32'(owner_out), 32'd2);
    tick();
    check("sw_bg_valid", 32'(bg_data_valid_out), 32'd1);
    check("sw_bg_data", 32'(bg_data_out), 32'h1A);
    check("sw_spr_valid", 32'(spr_data_valid_out), 32'd0);
    bg_addr_valid_in = 1'b0;
    tick();
    check("sw_bg_drop", 32'(bg_data_valid_out), 32'd0);

    // Non-owner and out-of-range fetches are never issued
    bg_mem_busy_in = 1'b1;
    pulse_tclk();
    spr_addr_in = 16'h8021; spr_addr_valid_in = 1'b1;
    #1;
    check("nonown_addr", 32'(vram_addr_out), 32'h0000);
    repeat (2) tick();
    check("nonown_valid", 32'(spr_data_valid_out), 32'd0);
    spr_addr_valid_in = 1'b0;
    bg_addr_in = 16'hFE00; bg_addr_valid_in = 1'b1;
    #1;
    check("oor_addr", 32'(vram_addr_out), 32'h0000);
    repeat (2) tick();
    check("oor_valid", 32'(bg_data_valid_out), 32'd0);
    bg_addr_valid_in = 1'b0;

    // LCD off: the CPU has access even in mode 3
    lcd_on_in = 1'b0;
    pulse_tclk();
    check("lcdoff_owner", 32'(owner_out), 32'd0);
    cpu_addr_in = 16'h8010; cpu_rd_in = 1'b1;
    #1;
    check("lcdoff_addr", 32'(vram_addr_out), 32'h0010);
    tick();
    cpu_rd_in = 1'b0;
    tick();
    check("lcdoff_valid", 32'(cpu_rdata_valid_out), 32'd1);
    check("lcdoff_data", 32'(cpu_rdata_out), 32'h5A);
    // An out-of-range CPU read is ignored
    cpu_addr_in = 16'h7FFF; cpu_rd_in = 1'b1;
    tick();
    cpu_rd_in = 1'b0;
    check("cpu_oor_valid", 32'(cpu_rdata_valid_out), 32'd0);
    tick();
    check("cpu_oor_valid2", 32'(cpu_rdata_valid_out), 32'd0);

    // Reset with a CPU read in flight
    cpu_addr_in = 16'h8010; cpu_rd_in = 1'b1;
    tick();
    cpu_rd_in = 1'b0;
    #2;
    rst_n_in = 1'b0;
    #1;
    check("arst_cpu_data", 32'(cpu_rdata_out), 32'h00);
    check("arst_bg_data", 32'(bg_data_out), 32'h00);
    check("arst_spr_data", 32'(spr_data_out), 32'h00);
    check("arst_count", 32'(cpu_blocked_count_out), 32'd0);
    check("arst_owner", 32'(owner_out), 32'd0);
    check("arst_cpu_valid", 32'(cpu_rdata_valid_out), 32'd0);
    repeat (2) tick();
    rst_n_in = 1'b1;
    tick();
    check("arst_no_stale1", 32'(cpu_rdata_valid_out), 32'd0);
    tick();
    check("arst_no_stale2", 32'(cpu_rdata_valid_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
